// File: rtl/aes_port_sched.sv
// rtl/aes_port_sched.sv - frame scheduler between UART byte ports and an AES-128 core
//
// Decodes rx frames (header + 16 payload bytes, MSB first). Header 8'h4B loads
// the key, header 8'h44 encrypts one block and streams the 16 result bytes to tx.
// Only one block is in flight at a time.
//
// Optional feature: define AES_SCHED_TIMEOUT_EN to abort a partial frame after
// TIMEOUT_CYC idle cycles (err_tout pulse). Without it err_tout is tied low.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rx_vld, rx_byte, rx_rdy     rx byte stream (transfer on rx_vld & rx_rdy)
//   core_key, core_key_ld       key to the core and its one-cycle load pulse
//   core_din, core_start        plaintext and one-cycle start pulse
//   core_busy, core_done        core status; core_dout valid with core_done
//   core_dout                   ciphertext from the core
//   tx_vld, tx_byte, tx_rdy     tx byte stream (transfer on tx_vld & tx_rdy)
//   key_valid                   a key has been loaded since reset
//   err_hdr, err_nokey, err_tout one-cycle error pulses
module aes_port_sched #(
    parameter int TIMEOUT_CYC = 1000,
    parameter int TOUT_W      = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_vld,
    input  logic [7:0]   rx_byte,
    output logic         rx_rdy,
    output logic [127:0] core_key,
    output logic         core_key_ld,
    output logic [127:0] core_din,
    output logic         core_start,
    input  logic         core_busy,
    input  logic         core_done,
    input  logic [127:0] core_dout,
    output logic         tx_vld,
    output logic [7:0]   tx_byte,
    input  logic         tx_rdy,
    output logic         key_valid,
    output logic         err_hdr,
    output logic         err_nokey,
    output logic         err_tout
);

    typedef enum logic [2:0] {
        IDLE, COL_KEY, COL_DAT, DROP, KEY_LD, START, WAIT, SEND
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    // Only 15 bytes need storing: the 16th is appended straight from rx_byte.
    logic [119:0]   rx_sh_q, rx_sh_d;
    logic [127:0]   core_key_q, core_key_d;
    logic [127:0]   core_din_q, core_din_d;
    logic [127:0]   tx_sh_q, tx_sh_d;
    logic           key_valid_q, key_valid_d;
    logic           err_hdr_q, err_hdr_d;
    logic           err_nokey_q, err_nokey_d;
    logic           rx_hs;
    logic           collecting;

`ifdef AES_SCHED_TIMEOUT_EN
    logic [TOUT_W-1:0] tout_q, tout_d;
    logic              err_tout_q, err_tout_d;
`endif

    assign rx_hs      = rx_vld & rx_rdy;
    assign collecting = (state_q == COL_KEY) || (state_q == COL_DAT) || (state_q == DROP);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rx_sh_q     <= '0;
            core_key_q  <= '0;
            core_din_q  <= '0;
            tx_sh_q     <= '0;
            key_valid_q <= 1'b0;
            err_hdr_q   <= 1'b0;
            err_nokey_q <= 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
            tout_q      <= '0;
            err_tout_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_sh_q     <= rx_sh_d;
            core_key_q  <= core_key_d;
            core_din_q  <= core_din_d;
            tx_sh_q     <= tx_sh_d;
            key_valid_q <= key_valid_d;
            err_hdr_q   <= err_hdr_d;
            err_nokey_q <= err_nokey_d;
`ifdef AES_SCHED_TIMEOUT_EN
            tout_q      <= tout_d;
            err_tout_q  <= err_tout_d;
`endif
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_sh_d     = rx_sh_q;
        core_key_d  = core_key_q;
        core_din_d  = core_din_q;
        tx_sh_d     = tx_sh_q;
        key_valid_d = key_valid_q;
        err_hdr_d   = 1'b0;
        err_nokey_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_hs) begin
                    cnt_d = 4'd0;
                    case (rx_byte)
                        8'h4B: state_d = COL_KEY;
                        8'h44: begin
                            if (key_valid_q) begin
                                state_d = COL_DAT;
                            end else begin
                                err_nokey_d = 1'b1;
                                state_d     = DROP;
                            end
                        end
                        default: err_hdr_d = 1'b1;
                    endcase
                end
            end
            COL_KEY, COL_DAT, DROP: begin
                if (rx_hs) begin
                    rx_sh_d = {rx_sh_q[111:0], rx_byte};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        if (state_q == COL_KEY) begin
                            // Key register only changes on a complete frame, so
                            // it is visible together with the KEY_LD pulse.
                            core_key_d  = {rx_sh_q, rx_byte};
                            key_valid_d = 1'b1;
                            state_d     = KEY_LD;
                        end else if (state_q == COL_DAT) begin
                            core_din_d = {rx_sh_q, rx_byte};
                            state_d    = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            KEY_LD: state_d = IDLE;
            START: begin
                if (!core_busy) state_d = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    tx_sh_d = core_dout;
                    cnt_d   = 4'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_rdy) begin
                    tx_sh_d = {tx_sh_q[119:0], 8'h00};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef AES_SCHED_TIMEOUT_EN
        // Idle-cycle counter inside a frame; firing abandons the partial frame.
        err_tout_d = 1'b0;
        tout_d     = '0;
        if (collecting && !rx_hs) begin
            if (tout_q == TOUT_W'(TIMEOUT_CYC - 1)) begin
                err_tout_d = 1'b1;
                state_d    = IDLE;
                cnt_d      = 4'd0;
            end else begin
                tout_d = tout_q + 1'b1;
            end
        end
`endif
    end

    // Outputs
    always_comb begin
        rx_rdy      = rst_n && (collecting || (state_q == IDLE));
        core_key_ld = (state_q == KEY_LD);
        core_start  = (state_q == START) && !core_busy;
        tx_vld      = (state_q == SEND);
    end

    assign core_key  = core_key_q;
    assign core_din  = core_din_q;
    assign tx_byte   = tx_sh_q[127:120];
    assign key_valid = key_valid_q;
    assign err_hdr   = err_hdr_q;
    assign err_nokey = err_nokey_q;

`ifdef AES_SCHED_TIMEOUT_EN
    assign err_tout = err_tout_q;
`else
    // Constant low in this build; the parameters only matter with the timeout.
    assign err_tout = (TIMEOUT_CYC < 0) && (TOUT_W < 0);
`endif

endmodule

// File: tb/tb_aes_port_sched.sv
// tb/tb_aes_port_sched.sv - self-checking bench for aes_port_sched
module tb_aes_port_sched;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx_vld = 1'b0;
    logic [7:0]   rx_byte = 8'h00;
    logic         rx_rdy;
    logic [127:0] core_key;
    logic         core_key_ld;
    logic [127:0] core_din;
    logic         core_start;
    logic         core_busy;
    logic         mdl_busy = 1'b0;
    logic         ext_busy = 1'b0;
    logic         core_done = 1'b0;
    logic [127:0] core_dout = '0;
    logic         tx_vld;
    logic [7:0]   tx_byte;
    logic         tx_rdy = 1'b0;
    logic         key_valid;
    logic         err_hdr;
    logic         err_nokey;
    logic         err_tout;

    assign core_busy = mdl_busy | ext_busy;

    always #5 clk = ~clk;

    aes_port_sched #(.TIMEOUT_CYC(20), .TOUT_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_vld(rx_vld), .rx_byte(rx_byte), .rx_rdy(rx_rdy),
        .core_key(core_key), .core_key_ld(core_key_ld),
        .core_din(core_din), .core_start(core_start),
        .core_busy(core_busy), .core_done(core_done), .core_dout(core_dout),
        .tx_vld(tx_vld), .tx_byte(tx_byte), .tx_rdy(tx_rdy),
        .key_valid(key_valid), .err_hdr(err_hdr), .err_nokey(err_nokey), .err_tout(err_tout)
    );

    int errs = 0;
    int checks = 0;
    int n_keyld = 0, n_start = 0, n_hdr = 0, n_nokey = 0, n_tout = 0;
    int busy_viol = 0, stall_viol = 0, excl_viol = 0, len_viol = 0, tmo_cnt = 0;
    int rx_wait_max = 0;
    int exp_keyld = 0;
    int tx_mode = 0;
    logic [127:0] start_din = '0, start_key = '0;
    logic [7:0]   tx_q[$];

    typedef struct {
        logic         load_key;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           txm;
        logic         gap;
    } vec_t;
    vec_t vecs[6];

    // Stand-in cipher: the known AES vector, otherwise an arbitrary mix.
    function automatic logic [127:0] ref_ct(input logic [127:0] k, input logic [127:0] p);
        if (k == K0 && p == P0) return C0;
        return {p[63:0], p[127:64]} ^ k ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_vld  = 1'b1;
        rx_byte = b;
        while (!rx_rdy && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) tmo_cnt++;
        if (n > rx_wait_max) rx_wait_max = n;
        step();
    endtask

    // Leaves rx_vld high so consecutive frames run back-to-back.
    task automatic send_frame(input logic [7:0] hdr, input logic [127:0] pay, input logic gap);
        logic [127:0] sh = pay;
        send_byte(hdr);
        for (int i = 0; i < 16; i++) begin
            if (gap) begin
                rx_vld = 1'b0;
                repeat ($urandom_range(0, 2)) step();
            end
            send_byte(sh[127:120]);
            sh = sh << 8;
        end
        if (hdr == 8'h4B) exp_keyld++;
    endtask

    task automatic get_tx(output logic [127:0] got);
        int t = 0;
        while (tx_q.size() < 16 && t < 2000) begin
            step();
            t++;
        end
        if (t >= 2000) tmo_cnt++;
        got = '0;
        while (tx_q.size() > 0) got = {got[119:0], tx_q.pop_front()};
        t = 0;
        while (tx_vld && t < 50) begin
            step();
            t++;
        end
    endtask

    // Core model: busy for a few cycles after start, then a done pulse.
    initial begin
        logic [127:0] ck, cd;
        forever begin
            @(negedge clk);
            if (core_start) begin
                ck = core_key;
                cd = core_din;
                @(posedge clk);
                #1 mdl_busy = 1'b1;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
                mdl_busy  = 1'b0;
                core_done = 1'b1;
                core_dout = ref_ct(ck, cd);
                @(posedge clk);
                #1 core_done = 1'b0;
            end
        end
    end

    // tx sink readiness
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (tx_mode)
                0:       tx_rdy = 1'b1;
                1:       tx_rdy = ~tx_rdy;
                default: tx_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor
    initial begin
        logic       prev_vld = 1'b0, prev_rdy = 1'b0;
        logic [7:0] prev_byte = 8'h00;
        logic [2:0] prev_err = 3'b000;
        logic [2:0] ev;
        forever begin
            @(negedge clk);
            ev = {err_hdr, err_nokey, err_tout};
            if (rst_n) begin
                if (core_key_ld) n_keyld++;
                if (core_start) begin
                    n_start++;
                    start_din = core_din;
                    start_key = core_key;
                    if (core_busy) busy_viol++;
                end
                if (err_hdr) n_hdr++;
                if (err_nokey) n_nokey++;
                if (err_tout) n_tout++;
                if ($countones(ev) > 1) excl_viol++;
                if ((ev & prev_err) != 3'b000) len_viol++;
                if (tx_vld && tx_rdy) tx_q.push_back(tx_byte);
                if (prev_vld && !prev_rdy && (!tx_vld || tx_byte != prev_byte)) stall_viol++;
            end
            prev_err  = ev;
            prev_vld  = tx_vld;
            prev_rdy  = tx_rdy;
            prev_byte = tx_byte;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errs, checks);
        $fatal(1);
    end

    initial begin
        logic [127:0] got;
        logic [127:0] cur_key;
        int s0, e0, n;

        // Reset state
        step(); step(); step();
        chk("rst_rx_rdy", rx_rdy, 0);
        chk("rst_tx_vld", tx_vld, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_core_key", core_key, 0);
        chk("rst_core_din", core_din, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_key_ld", core_key_ld, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_errs", {err_hdr, err_nokey, err_tout}, 0);
        rst_n = 1'b1;
        step();
        chk("idle_rx_rdy", rx_rdy, 1);

        // Data frame without a key is swallowed
        rx_wait_max = 0;
        send_frame(8'h44, P0, 1'b0);
        rx_vld = 1'b0;
        step();
        chk("nokey_pulse", n_nokey, 1);
        chk("nokey_no_start", n_start, 0);
        chk("nokey_rx_rdy_held", rx_wait_max, 0);

        // Unknown header
        send_byte(8'hAA);
        rx_vld = 1'b0;
        step();
        chk("bad_hdr_pulse", n_hdr, 1);
        chk("bad_hdr_idle", rx_rdy, 1);

        // Key load and its pulse timing
        send_frame(8'h4B, K0, 1'b0);
        rx_vld = 1'b0;
        chk("keyld_pulse", core_key_ld, 1);
        chk("keyld_key", core_key, K0);
        chk("keyld_valid", key_valid, 1);
        step();
        chk("keyld_one_cycle", core_key_ld, 0);
        cur_key = K0;

        // Start held off by core_busy, then released
        tx_mode = 0;
        ext_busy = 1'b1;
        s0 = n_start;
        send_frame(8'h44, P0, 1'b0);
        rx_vld = 1'b0;
        chk("busy_hold_start0", core_start, 0);
        step(); step(); step();
        chk("busy_hold_start1", core_start, 0);
        chk("busy_hold_count", n_start - s0, 0);
        @(posedge clk);
        #1 ext_busy = 1'b0;
        step();
        get_tx(got);
        chk("busy_release_start", n_start - s0, 1);
        chk("busy_release_ct", got, C0);

        // Table of encryptions
        vecs[0] = '{1'b1, K0, P0, C0, 0, 1'b0};
        vecs[1] = '{1'b0, K0, P0, C0, 1, 1'b0};
        for (int i = 2; i < 6; i++) begin
            vecs[i].load_key = (i != 3);
            vecs[i].key = vecs[i].load_key ? {$urandom, $urandom, $urandom, $urandom} : vecs[i-1].key;
            vecs[i].pt  = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].ct  = ref_ct(vecs[i].key, vecs[i].pt);
            vecs[i].txm = 2;
            vecs[i].gap = 1'(i % 2);
        end
        for (int i = 0; i < 6; i++) begin
            tx_mode = vecs[i].txm;
            s0 = n_start;
            if (vecs[i].load_key) begin
                send_frame(8'h4B, vecs[i].key, vecs[i].gap);
                cur_key = vecs[i].key;
            end
            send_frame(8'h44, vecs[i].pt, vecs[i].gap);
            rx_vld = 1'b0;
            if (i == 0) chk("start_latency", core_start, 1);
            get_tx(got);
            chk($sformatf("vec%0d_ct", i), got, vecs[i].ct);
            chk($sformatf("vec%0d_starts", i), n_start - s0, 1);
            chk($sformatf("vec%0d_din", i), start_din, vecs[i].pt);
            chk($sformatf("vec%0d_key", i), start_key, cur_key);
            chk($sformatf("vec%0d_idle", i), {tx_vld, rx_rdy}, 2'b01);
        end
        tx_mode = 0;

        // Reset in the middle of a data frame
        send_byte(8'h44);
        for (int i = 0; i < 8; i++) send_byte(8'(i));
        rst_n = 1'b0;
        rx_vld = 1'b0;
        step();
        chk("midrst_outputs", {rx_rdy, tx_vld, tx_byte, core_start, core_key_ld, err_hdr, err_nokey, err_tout}, 0);
        chk("midrst_key", core_key, 0);
        chk("midrst_din", core_din, 0);
        chk("midrst_key_valid", key_valid, 0);
        rst_n = 1'b1;
        step();
        s0 = n_start;
        e0 = n_nokey;
        send_frame(8'h44, P0, 1'b0);
        rx_vld = 1'b0;
        step();
        chk("midrst_nokey", n_nokey - e0, 1);
        chk("midrst_no_start", n_start - s0, 0);
        send_frame(8'h4B, K0, 1'b0);
        rx_vld = 1'b0;
        step();
        chk("midrst_reload", key_valid, 1);

        // Stalled partial frame
        send_byte(8'h44);
        for (int i = 0; i < 5; i++) send_byte(P0[127 - 8*i -: 8]);
        rx_vld = 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
        n = 0;
        while (!err_tout && n < 100) begin
            step();
            n++;
        end
        chk("tout_cycle", n, 20);
        chk("tout_idle", {tx_vld, rx_rdy}, 2'b01);
        chk("tout_key_kept", {key_valid, core_key}, {1'b1, K0});
        step();
        chk("tout_one_pulse", n_tout, 1);
        s0 = n_start;
        send_frame(8'h44, P0, 1'b0);
        rx_vld = 1'b0;
`else
        n = 0;
        repeat (40) step();
        chk("notout_pulse", n_tout, 0);
        chk("notout_waiting", rx_rdy, 1);
        s0 = n_start;
        for (int i = 5; i < 16; i++) send_byte(P0[127 - 8*i -: 8]);
        rx_vld = 1'b0;
`endif
        get_tx(got);
        chk("after_stall_ct", got, C0);
        chk("after_stall_start", n_start - s0, 1);

        // Whole-run properties
        chk("keyld_count", n_keyld, exp_keyld);
        chk("start_while_busy", busy_viol, 0);
        chk("tx_stall_stable", stall_viol, 0);
        chk("err_exclusive", excl_viol, 0);
        chk("err_one_cycle", len_viol, 0);
        chk("wait_bounds", tmo_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
